trace_cmd_queue: RTL

Synthesizable command queue between the trace reader and the LLC model. It accepts `{command, address}` trace records over a valid/ready handshake and drops illegal command codes. It buffers legal records in a DEPTH-entry FIFO, splits each address into tag/index/offset, and presents the records to the LLC one per handshake. It also keeps read/write/drop statistics that the trace-clear command (8) resets.

---
 rtl/trace_cmd_queue.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/trace_cmd_queue.sv
// Command queue between the trace reader and the LLC model: filters illegal commands, buffers legal records, splits addresses, and keeps statistics.
// Latency: 1 cycle from input accept to out_valid (0 cycles with TRACE_Q_BYPASS_EN when the queue is empty).
// Backpressure: in_ready = (count != DEPTH) from registered state only; the head record is held while out_ready is low.
// Optional feature macro: TRACE_Q_BYPASS_EN (empty-queue combinational bypass).
module trace_cmd_queue #(
    parameter int CMDSIZE     = 4,
    parameter int ADDR_BITS   = 32,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 14,
    parameter int DEPTH       = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [CMDSIZE-1:0]                        in_cmd,
    input  logic [ADDR_BITS-1:0]                      in_addr,
    input  logic                                      in_last,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [CMDSIZE-1:0]                        out_cmd,
    output logic [ADDR_BITS-INDEX_BITS-OFFSET_BITS-1:0] out_tag,
    output logic [INDEX_BITS-1:0]                     out_index,
    output logic [OFFSET_BITS-1:0]                    out_offset,
    output logic [$clog2(DEPTH):0]                    count,
    output logic [31:0]                               reads,
    output logic [31:0]                               writes,
    output logic [31:0]                               dropped,
    output logic                                      done
);

    localparam int TAGW = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   SAT_MAX  = 32'hFFFF_FFFF;

    localparam logic [CMDSIZE-1:0] CMD_READ0 = CMDSIZE'(0);
    localparam logic [CMDSIZE-1:0] CMD_WRITE = CMDSIZE'(1);
    localparam logic [CMDSIZE-1:0] CMD_READ2 = CMDSIZE'(2);
    localparam logic [CMDSIZE-1:0] CMD_LAST6 = CMDSIZE'(6);
    localparam logic [CMDSIZE-1:0] CMD_CLEAR = CMDSIZE'(8);
    localparam logic [CMDSIZE-1:0] CMD_NINE  = CMDSIZE'(9);

    // Legal codes are 0..6, 8 and 9; everything else is dropped at the input.
    function automatic logic cmd_legal(input logic [CMDSIZE-1:0] c);
        cmd_legal = (c <= CMD_LAST6) || (c == CMD_CLEAR) || (c == CMD_NINE);
    endfunction

    // Record storage; not reset because only entries inside the occupied window are ever read.
    logic [CMDSIZE-1:0]   mem_cmd  [DEPTH];
    logic [ADDR_BITS-1:0] mem_addr [DEPTH];

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        rd_ptr_nx;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_nx;

    // Registered copy of the head record, so out_* hold their last values once the queue empties.
    logic [CMDSIZE-1:0]   head_cmd;
    logic [ADDR_BITS-1:0] head_addr;
    logic [CMDSIZE-1:0]   head_cmd_nx;
    logic [ADDR_BITS-1:0] head_addr_nx;

    logic                 in_fire;
    logic                 in_is_legal;
    logic                 in_drop;
    logic                 byp;
    logic                 byp_take;
    logic                 out_fire;
    logic                 wr_en;
    logic                 rd_en;
    logic                 last_seen;

    logic [CMDSIZE-1:0]   sel_cmd;
    logic [ADDR_BITS-1:0] sel_addr;

    assign in_is_legal = cmd_legal(in_cmd);
    assign in_ready    = (count_q != FULL_CNT);
    assign in_fire     = in_valid & in_ready;
    assign in_drop     = in_fire & ~in_is_legal;

`ifdef TRACE_Q_BYPASS_EN
    // Empty queue with a legal record waiting: show it directly on the output.
    assign byp = (count_q == '0) & in_valid & in_is_legal;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = (count_q != '0) | byp;
    assign out_fire  = out_valid & out_ready;
    assign byp_take  = byp & out_ready;

    // A bypassed record that is consumed immediately never touches the storage.
    assign wr_en = in_fire & in_is_legal & ~byp_take;
    assign rd_en = out_fire & ~byp;

    assign rd_ptr_nx = rd_ptr + PW'(rd_en);
    assign count_nx  = count_q + CW'(wr_en) - CW'(rd_en);

    assign sel_cmd  = byp ? in_cmd  : head_cmd;
    assign sel_addr = byp ? in_addr : head_addr;

    assign out_cmd    = sel_cmd;
    assign out_tag    = sel_addr[ADDR_BITS-1 -: TAGW];
    assign out_index  = sel_addr[OFFSET_BITS +: INDEX_BITS];
    assign out_offset = sel_addr[OFFSET_BITS-1:0];

    assign count = count_q;
    assign done  = last_seen & (count_q == '0);

    // Next head: the bypassed record, the entry just written into an empty queue, or the stored entry at the next read pointer.
    always_comb begin
        head_cmd_nx  = head_cmd;
        head_addr_nx = head_addr;
        if (byp_take) begin
            head_cmd_nx  = in_cmd;
            head_addr_nx = in_addr;
        end else if (count_nx != '0) begin
            if (wr_en && (wr_ptr == rd_ptr_nx)) begin
                head_cmd_nx  = in_cmd;
                head_addr_nx = in_addr;
            end else begin
                head_cmd_nx  = mem_cmd[rd_ptr_nx];
                head_addr_nx = mem_addr[rd_ptr_nx];
            end
        end
    end

    // Storage write at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_cmd[wr_ptr]  <= in_cmd;
            mem_addr[wr_ptr] <= in_addr;
        end
    end

    // Pointers, occupancy and head register; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            head_cmd  <= '0;
            head_addr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_ptr_nx;
            count_q   <= count_nx;
            head_cmd  <= head_cmd_nx;
            head_addr <= head_addr_nx;
        end
    end

    // Statistics: counted on dequeue, saturating; a dequeued clear command wipes all three, keeping a same-edge drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads   <= '0;
            writes  <= '0;
            dropped <= '0;
        end else if (out_fire && (sel_cmd == CMD_CLEAR)) begin
            reads   <= '0;
            writes  <= '0;
            dropped <= in_drop ? 32'd1 : 32'd0;
        end else begin
            if (out_fire && ((sel_cmd == CMD_READ0) || (sel_cmd == CMD_READ2)) && (reads != SAT_MAX)) begin
                reads <= reads + 32'd1;
            end
            if (out_fire && (sel_cmd == CMD_WRITE) && (writes != SAT_MAX)) begin
                writes <= writes + 32'd1;
            end
            if (in_drop && (dropped != SAT_MAX)) begin
                dropped <= dropped + 32'd1;
            end
        end
    end

    // End-of-trace flag follows in_last of the most recent accepted record, legal or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seen <= 1'b0;
        end else if (in_fire) begin
            last_seen <= in_last;
        end
    end

endmodule
